// File: rtl/button_conditioner.sv
// Push-button conditioner for the reaction-timer front end.
// Each channel synchronises its raw pad level, debounces it with a
// four-state acceptance FSM, and emits a clean level plus one-cycle
// press / release pulses. The release pulse output is named
// release_pulse because "release" is a reserved word in SystemVerilog.
module button_conditioner #(
    parameter int N_BTN       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE0 = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] IDLE1 = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   btn_sync;
        logic [1:0]             state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   press_q;
        logic                   rel_q;

        // Shift the asynchronous pad level through the synchroniser chain.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
            end
        end

        assign btn_sync = sync_q[SYNC_STAGES-1];

        // Debounce FSM: a change is accepted only after DB_CYCLES stable samples.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state_q)
                    IDLE0: begin
                        if (btn_sync) begin
                            state_q <= WAIT1;
                            cnt_q   <= '0;
                        end
                    end
                    WAIT1: begin
                        if (!btn_sync) begin
                            state_q <= IDLE0;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE1;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    IDLE1: begin
                        if (!btn_sync) begin
                            state_q <= WAIT0;
                            cnt_q   <= '0;
                        end
                    end
                    WAIT0: begin
                        if (btn_sync) begin
                            state_q <= IDLE1;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE0;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE0;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign level[g]         = level_q;
        assign press[g]         = press_q;
        assign release_pulse[g] = rel_q;
    end

endmodule
